// File: rtl/mem_lsu_pkg.sv
// Shared types and funct3 decode helpers for the load/store unit.
package lsu_types;

    // Widest dcache bus the lane logic is written for (64-bit).
    localparam int MAX_BYTES = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_DONE  = 2'd3
    } lsu_state_t;

    // Access size in bytes from funct3[1:0]: byte, half, word.
    function automatic logic [2:0] f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Sign-extend for lb/lh; lbu/lhu zero-extend and lw needs no extension.
    function automatic logic f3_signed(input logic [2:0] f3);
        return ~f3[2] & (f3[1:0] != 2'b10);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store shift/enables per beat, load merge and extend.
module mem_align
    import lsu_types::*;
#(
    parameter  int DATA_W = 32,
    localparam int BYTES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(BYTES)
) (
    input  logic              active,
    input  logic              beat,
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        funct3,
    input  logic [31:0]       sdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic [31:0]       buf_in,
    output logic [BYTES-1:0]  byte_en,
    output logic [DATA_W-1:0] wdata,
    output logic [31:0]       merged,
    output logic [31:0]       ext
);

    logic [2:0] size;
    logic       sgn;

    assign size = f3_size(funct3[1:0]);
    assign sgn  = f3_signed(funct3);

    // Map every dcache lane to its access-relative byte; beat 1 continues
    // where beat 0 ran off the top lane, so its lane 0 is byte BYTES-off.
    always_comb begin
        int rel;
        rel     = 0;
        byte_en = '0;
        wdata   = '0;
        merged  = buf_in;
        for (int l = 0; l < BYTES; l++) begin
            rel = beat ? (BYTES - int'(off) + l) : (l - int'(off));
            if (active && rel >= 0 && rel < int'(size)) begin
                byte_en[l]             = 1'b1;
                wdata[8*l +: 8]        = sdata[8*rel[1:0] +: 8];
                merged[8*rel[1:0] +: 8] = rdata[8*l +: 8];
            end
        end
    end

    // Extend the assembled load bytes to 32 bits.
    always_comb begin
        ext = buf_in;
        case (size)
            3'd1:    ext = {{24{sgn & buf_in[7]}}, buf_in[7:0]};
            3'd2:    ext = {{16{sgn & buf_in[15]}}, buf_in[15:0]};
            default: ext = buf_in;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: turns an EX/MEM access into one or two dcache beats,
// stalls the pipeline until the access retires.
module mem_lsu
    import lsu_types::*;
#(
    parameter  int DATA_W           = 32,
    parameter  int ALLOW_MISALIGNED = 1,
    localparam int BYTES            = DATA_W / 8,
    localparam int OFF_W            = $clog2(BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exmem_valid,
    input  logic              exmem_read,
    input  logic              exmem_write,
    input  logic [2:0]        exmem_funct3,
    input  logic [31:0]       exmem_alu_out,
    input  logic [31:0]       exmem_rs2_out,
    output logic [31:0]       dcache_addr,
    output logic              dcache_read,
    output logic              dcache_write,
    output logic [BYTES-1:0]  dcache_byte_enable,
    output logic [DATA_W-1:0] dcache_wdata,
    input  logic              dcache_resp,
    input  logic [DATA_W-1:0] dcache_rdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_misalign,
    output logic              mem_stall
);

    lsu_state_t  state_q, state_d;
    logic        is_read_q, is_read_d;
    logic        is_write_q, is_write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] buf_q, buf_d;
    logic        misalign_q, misalign_d;

    logic              start;
    logic              split_in;
    logic              split_cur;
    logic              req_active;
    logic              beat1;
    logic [31:0]       base;
    logic [BYTES-1:0]  be_w;
    logic [DATA_W-1:0] wd_w;
    logic [31:0]       merged_w;
    logic [31:0]       ext_w;

    assign start      = (state_q == S_IDLE) && exmem_valid && (exmem_read || exmem_write);
    assign split_in   = (int'(exmem_alu_out[OFF_W-1:0]) + int'(f3_size(exmem_funct3[1:0]))) > BYTES;
    assign split_cur  = (int'(addr_q[OFF_W-1:0]) + int'(f3_size(funct3_q[1:0]))) > BYTES;
    assign req_active = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign beat1      = (state_q == S_BEAT1);
    assign base       = {addr_q[31:OFF_W], {OFF_W{1'b0}}};

    mem_align #(.DATA_W(DATA_W)) u_align (
        .active  (req_active),
        .beat    (beat1),
        .off     (addr_q[OFF_W-1:0]),
        .funct3  (funct3_q),
        .sdata   (sdata_q),
        .rdata   (dcache_rdata),
        .buf_in  (buf_q),
        .byte_en (be_w),
        .wdata   (wd_w),
        .merged  (merged_w),
        .ext     (ext_w)
    );

    // Next state, operand latches and load merge buffer.
    always_comb begin
        state_d    = state_q;
        is_read_d  = is_read_q;
        is_write_d = is_write_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        buf_d      = buf_q;
        misalign_d = misalign_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_read_d  = exmem_read;
                    is_write_d = exmem_write;
                    funct3_d   = exmem_funct3;
                    addr_d     = exmem_alu_out;
                    sdata_d    = exmem_rs2_out;
                    buf_d      = '0;
                    misalign_d = split_in && (ALLOW_MISALIGNED == 0);
                    state_d    = (split_in && (ALLOW_MISALIGNED == 0)) ? S_DONE : S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (dcache_resp) begin
                    if (is_read_q) buf_d = merged_w;
                    state_d = split_cur ? S_BEAT1 : S_DONE;
                end
            end
            S_BEAT1: begin
                if (dcache_resp) begin
                    if (is_read_q) buf_d = merged_w;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Requests and results come straight from registered state.
    always_comb begin
        dcache_addr        = '0;
        dcache_read        = 1'b0;
        dcache_write       = 1'b0;
        dcache_byte_enable = '0;
        dcache_wdata       = '0;
        if (req_active) begin
            dcache_addr        = beat1 ? (base + 32'(BYTES)) : base;
            dcache_read        = is_read_q;
            dcache_write       = is_write_q;
            dcache_byte_enable = be_w;
            dcache_wdata       = wd_w;
        end
        mem_done     = (state_q == S_DONE);
        mem_misalign = (state_q == S_DONE) && misalign_q;
        mem_rdata    = ((state_q == S_DONE) && is_read_q) ? ext_w : 32'h0;
        mem_stall    = start || req_active;
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_read_q  <= 1'b0;
            is_write_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            buf_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_read_q  <= is_read_d;
            is_write_q <= is_write_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            buf_q      <= buf_d;
            misalign_q <= misalign_d;
        end
    end

endmodule
